// File: rtl/mm_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_sram_pkg
// Description : Shared types, default constants and helpers for the SRAM
//               responder on the Gameboy memory-map bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ACK    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [15:0] DEF_WIN_BASE    = 16'hA000;
    localparam logic [15:0] DEF_WIN_SIZE    = 16'h2000;
    localparam logic [15:0] DEF_BANK_ADDR   = 16'h4000;
    localparam int          DEF_BANK_W      = 4;
    localparam int          DEF_WAIT_CYCLES = 2;

    // Offset of addr into a window at base; wraps so that a single unsigned
    // compare against the window size decodes the window.
    function automatic logic [15:0] win_offset(input logic [15:0] addr,
                                               input logic [15:0] base);
        return addr - base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_win_decode.sv
`default_nettype none
// ============================================================================
// Module      : mm_win_decode
// Description : Combinational address decode for a memory-map responder:
//               RAM window hit, bank-register hit and bus claim.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_win_decode
    import mm_sram_pkg::*;
#(
    parameter logic [15:0] WIN_BASE  = DEF_WIN_BASE,
    parameter logic [15:0] WIN_SIZE  = DEF_WIN_SIZE,
    parameter logic [15:0] BANK_ADDR = DEF_BANK_ADDR
) (
    input  logic [15:0] mm_addr,
    input  logic        mm_rd,
    input  logic        mm_wr,
    output logic        in_win,
    output logic        is_bank,
    output logic        mm_sel
);

    always_comb begin
        in_win  = win_offset(mm_addr, WIN_BASE) < WIN_SIZE;
        is_bank = mm_addr == BANK_ADDR;
        mm_sel  = (mm_rd | mm_wr) & (in_win | is_bank);
    end

endmodule
`default_nettype wire

// File: rtl/mm_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : mm_sram_resp
// Description : Memory-map bus responder serving the cartridge RAM window
//               from an asynchronous SRAM with wait states and a bank register.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_sram_resp
    import mm_sram_pkg::*;
#(
    parameter logic [15:0] WIN_BASE    = DEF_WIN_BASE,
    parameter logic [15:0] WIN_SIZE    = DEF_WIN_SIZE,
    parameter logic [15:0] BANK_ADDR   = DEF_BANK_ADDR,
    parameter int          BANK_W      = DEF_BANK_W,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          SRAM_AW     = BANK_W + $clog2(WIN_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        mm_addr,
    input  logic [7:0]         mm_wdata,
    input  logic               mm_rd,
    input  logic               mm_wr,
    output logic [7:0]         mm_rdata,
    output logic               mm_ack,
    output logic               mm_sel,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_dq_o,
    input  logic [7:0]         sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam int         OFF_W    = $clog2(WIN_SIZE);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic               w_in_win;
    logic               w_is_bank;
    logic [15:0]        w_off;
    logic               unused_off;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic               is_bank_q, is_bank_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;

    mm_win_decode #(
        .WIN_BASE  (WIN_BASE),
        .WIN_SIZE  (WIN_SIZE),
        .BANK_ADDR (BANK_ADDR)
    ) u_decode (
        .mm_addr (mm_addr),
        .mm_rd   (mm_rd),
        .mm_wr   (mm_wr),
        .in_win  (w_in_win),
        .is_bank (w_is_bank),
        .mm_sel  (mm_sel)
    );

    assign w_off      = win_offset(mm_addr, WIN_BASE);
    assign unused_off = ^{w_off, w_in_win};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            is_wr_q   <= 1'b0;
            is_bank_q <= 1'b0;
            bank_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            is_bank_q <= is_bank_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        is_bank_d = is_bank_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mm_sel) begin
                    // A combined read+write request is a write.
                    is_wr_d   = mm_wr;
                    is_bank_d = w_is_bank;
                    if (w_is_bank) begin
                        state_d = ST_ACK;
                        if (mm_wr) begin
                            bank_d = mm_wdata[BANK_W-1:0];
                        end else begin
                            rdata_d = 8'(bank_q);
                        end
                    end else begin
                        state_d = ST_SETUP;
                        addr_d  = {bank_q, w_off[OFF_W-1:0]};
                        if (mm_wr) begin
                            wdata_d = mm_wdata;
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    if (!is_wr_q) begin
                        rdata_d = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // One access per request: wait for the master to let go.
                if (!mm_rd && !mm_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        mm_ack     = 1'b0;
        case (state_q)
            ST_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = is_wr_q;
            end
            ST_ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = is_wr_q;
                sram_we_n  = ~is_wr_q;
                sram_oe_n  = is_wr_q;
            end
            ST_ACK: begin
                mm_ack = 1'b1;
                if (!is_bank_q) begin
                    sram_ce_n  = 1'b0;
                    sram_dq_oe = is_wr_q;
                end
            end
            default: begin
                sram_ce_n = 1'b1;
            end
        endcase
    end

    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign mm_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: doc/mm_sram_resp.md
Name: mm_sram_resp

Overview:
- Responder (slave) end of the Gameboy memory-map bus.
- Claims the cartridge external-RAM window, serves byte reads and writes from an external asynchronous SRAM with programmable wait states, and acknowledges each transfer to the bus master.
- Holds an MBC-style bank register so the 8 KiB CPU window can reach a larger SRAM.
- Sits between the memory-map controller and the board SRAM pins.

Parameters:
- WIN_BASE, 16'hA000, first byte address of the claimed RAM window.
- WIN_SIZE, 16'h2000, window size in bytes; must be a power of two.
- BANK_ADDR, 16'h4000, write/read address of the bank register; must lie outside the window.
- BANK_W, 4, bank register width.
- WAIT_CYCLES, 2, number of strobe-active SRAM cycles; legal range 1..15.
- SRAM_AW, BANK_W+$clog2(WIN_SIZE), SRAM address width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mm_addr  in  16  bus address; stable while mm_rd/mm_wr is high
- mm_wdata  in  8  write data
- mm_rd  in  1  read request (level)
- mm_wr  in  1  write request (level)
- mm_rdata  out  8  read data; valid while mm_ack is high
- mm_ack  out  1  one-cycle transfer-complete pulse
- mm_sel  out  1  combinational: request address is claimed by this block
- sram_addr  out  SRAM_AW  SRAM address
- sram_dq_o  out  8  SRAM write data
- sram_dq_i  in  8  SRAM read data
- sram_dq_oe  out  1  drive enable for the SRAM data pins
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- Clock and reset are fixed:
  - single clock, clk;
  - reset is synchronous and active-high on rst.
- Address decode:
  - mm_sel = (mm_rd|mm_wr) & (in_win | mm_addr==BANK_ADDR);
  - in_win = (mm_addr - WIN_BASE) < WIN_SIZE, compared unsigned at 16 bits.
- Unclaimed addresses: no response. The block stays IDLE, never pulses mm_ack, and drives no SRAM strobes.
- Simultaneous mm_rd and mm_wr: treated as a write.
- SRAM address is {bank, (mm_addr-WIN_BASE)[$clog2(WIN_SIZE)-1:0]}, registered on leaving IDLE.
- FSM states: IDLE, SETUP, ACCESS, ACK, DONE.
  - IDLE, window request seen at cycle 0:
    - go to SETUP at cycle 1;
    - latch address, direction and wdata;
    - sram_ce_n=0; on a write, sram_dq_oe=1 with sram_dq_o=wdata.
  - ACCESS lasts exactly WAIT_CYCLES cycles, counted by a down-counter:
    - read: sram_oe_n=0;
    - write: sram_we_n=0;
    - read data is sampled from sram_dq_i on the last ACCESS cycle into mm_rdata.
  - ACK:
    - mm_ack=1 for one cycle;
    - ce_n stays 0, we_n/oe_n return to 1;
    - on a write, dq_oe stays 1 (data hold).
    - Ack appears in cycle 2+WAIT_CYCLES after the request cycle.
  - DONE:
    - all strobes inactive, dq_oe=0;
    - wait until mm_rd=0 and mm_wr=0, then go to IDLE.
    - This guarantees one access per request.
  - BANK_ADDR request in IDLE:
    - go directly to ACK (mm_ack in cycle 1) with no SRAM cycle;
    - write: bank <= mm_wdata[BANK_W-1:0];
    - read: mm_rdata = zero-extended bank.
- A request dropped before ack (master violation): the started access still completes, mm_ack still pulses, then DONE→IDLE.
- mm_rdata holds its last value outside ACK.
- Reset (including mid-access) takes effect at the next edge:
  - state=IDLE, bank=0, mm_rdata=0, mm_ack=0, mm_sel follows its inputs;
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- Invariant: we_n and oe_n are never low at the same time, and neither is low while ce_n=1.

Decomposition:
- Package mm_sram_pkg holds:
  - the state enum typedef;
  - the default window/bank constants;
  - a function win_offset(addr, base).
- Sub-module mm_win_decode (pure combinational in_win/is_bank/mm_sel) is natural and is reused by future responders.
- Everything else stays in one module.

Test Plan:
- Reset, then write 8'h5A to 16'hA123 with WAIT_CYCLES=2 -> mm_ack in cycle 4; sram_addr=0x0123; we_n low in cycles 2-3; dq_oe high in cycles 1-4.
- Write 8'h03 to 16'h4000, then read 16'hBFFF with SRAM model returning 8'hC7 -> bank ack in cycle 1; sram_addr=0x7FFF (width 17); mm_rdata=8'hC7 during ack.
- Read 16'h8000 and 16'hC000 -> mm_sel=0, no mm_ack within 20 cycles, all SRAM strobes stay high.
- Hold mm_rd high for 10 cycles after ack at 16'hA000 -> exactly one oe_n low window, one ack, block in DONE until mm_rd falls.
- Assert rst during ACCESS of a write -> next edge: we_n=1, ce_n=1, dq_oe=0, no ack; bank reads back 0.
- Assert mm_rd and mm_wr together at 16'hA001 -> write performed (we_n pulses, oe_n never low).
